// File: rtl/mac_rx_framer.sv
// rtl/mac_rx_framer.sv - Ethernet RX framer: preamble/SFD strip, FCS/length/PHY-error check, payload forward
//
// Purpose: consumes the byte-wide receive stream from the reconciliation
// sublayer, removes preamble and SFD, forwards payload bytes with the
// trailing 4-byte FCS stripped, and raises one status strobe per frame.
//
// Ports:
//   clk, reset             int_rx_clk, asynchronous active-high reset
//   rx_din, rx_dv, rx_er   receive byte, data valid, PHY error
//   out_data/valid/sof     payload byte stream, sof marks byte 0
//   stat_valid             one-cycle end-of-frame strobe qualifying stat_*
//   stat_good/crc_err/rx_err/len_err/len   frame status fields
module mac_rx_framer #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_din,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             stat_valid,
    output logic             stat_good,
    output logic             stat_crc_err,
    output logic             stat_rx_err,
    output logic             stat_len_err,
    output logic [LEN_W-1:0] stat_len
);

    typedef enum logic [2:0] {
        S_SYNC, S_IDLE, S_PREAMBLE, S_DATA, S_DONE, S_DROP
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] FCS_L    = LEN_W'(4);
    localparam logic [LEN_W-1:0] SLEN_MAX = LEN_W'(MAX_LEN - 3);
    localparam logic [31:0]      RESIDUE  = 32'hC704DD7B;

    // Reflected CRC-32: the register holds the CRC in LSB-first order.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // The residue constant is given in normal bit order, so compare bit-reversed.
    function automatic logic [31:0] bit_rev(input logic [31:0] c);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) begin
            r[k] = c[31-k];
        end
        return r;
    endfunction

    state_t            state_q;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              rxerr_q;
    logic [3:0][7:0]   dly_q;

    logic [7:0]        out_data_q;
    logic              out_valid_q, out_sof_q;
    logic              stat_valid_q, stat_good_q, stat_crc_q, stat_rx_q, stat_len_err_q;
    logic [LEN_W-1:0]  stat_len_q;

    // End-of-frame status terms, evaluated from the frame's final counters.
    logic              fin_len_err, fin_crc_err;
    logic [LEN_W-1:0]  fin_len;

    assign crc_d = crc_byte(crc_q, rx_din);
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

    assign fin_len_err = (cnt_q < MIN_L) || (cnt_q > MAX_L);
    assign fin_crc_err = (cnt_q < FCS_L) || (bit_rev(crc_q) != RESIDUE);
    assign fin_len     = (cnt_q < FCS_L) ? '0 :
                         (cnt_q > MAX_L) ? SLEN_MAX : (cnt_q - FCS_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_SYNC;
            crc_q          <= '1;
            cnt_q          <= '0;
            rxerr_q        <= 1'b0;
            dly_q          <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_good_q    <= 1'b0;
            stat_crc_q     <= 1'b0;
            stat_rx_q      <= 1'b0;
            stat_len_err_q <= 1'b0;
            stat_len_q     <= '0;
        end else begin
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_good_q    <= 1'b0;
            stat_crc_q     <= 1'b0;
            stat_rx_q      <= 1'b0;
            stat_len_err_q <= 1'b0;
            stat_len_q     <= '0;

            case (state_q)
                S_SYNC: begin
                    if (!rx_dv) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (rx_dv) state_q <= (rx_din == 8'h55) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (!rx_dv) begin
                        state_q <= S_IDLE;
                    end else if (rx_din == 8'hD5) begin
                        state_q <= S_DATA;
                        crc_q   <= '1;
                        cnt_q   <= '0;
                        rxerr_q <= 1'b0;
                    end else if (rx_din != 8'h55) begin
                        state_q <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (rx_dv) begin
                        crc_q   <= crc_d;
                        cnt_q   <= cnt_d;
                        rxerr_q <= rxerr_q | rx_er;
                        dly_q   <= {dly_q[2:0], rx_din};
                        // Oldest delay-line byte leaves once 4 bytes are held; the
                        // pre-increment count gates it so exactly MAX_LEN-3 beats pass.
                        if (cnt_q >= FCS_L && cnt_q <= MAX_L) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= dly_q[3];
                            out_sof_q   <= (cnt_q == FCS_L);
                        end
                    end else begin
                        state_q        <= S_DONE;
                        stat_valid_q   <= 1'b1;
                        stat_good_q    <= ~(fin_crc_err | rxerr_q | fin_len_err);
                        stat_crc_q     <= fin_crc_err;
                        stat_rx_q      <= rxerr_q;
                        stat_len_err_q <= fin_len_err;
                        stat_len_q     <= fin_len;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    if (!rx_dv) state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_sof      = out_sof_q;
    assign stat_valid   = stat_valid_q;
    assign stat_good    = stat_good_q;
    assign stat_crc_err = stat_crc_q;
    assign stat_rx_err  = stat_rx_q;
    assign stat_len_err = stat_len_err_q;
    assign stat_len     = stat_len_q;

endmodule

// File: tb/tb_mac_rx_framer.sv
// tb/tb_mac_rx_framer.sv - scoreboard bench for mac_rx_framer
module tb_mac_rx_framer;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
    localparam int LEN_W   = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_din;
    logic             rx_dv;
    logic             rx_er;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_sof;
    logic             stat_valid;
    logic             stat_good;
    logic             stat_crc_err;
    logic             stat_rx_err;
    logic             stat_len_err;
    logic [LEN_W-1:0] stat_len;

    always #5 clk = ~clk;

    mac_rx_framer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .rx_din(rx_din), .rx_dv(rx_dv), .rx_er(rx_er),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .stat_valid(stat_valid), .stat_good(stat_good), .stat_crc_err(stat_crc_err),
        .stat_rx_err(stat_rx_err), .stat_len_err(stat_len_err), .stat_len(stat_len)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_d[$];   // {sof, data}
    logic [14:0] exp_s[$];   // {good, crc_err, rx_err, len_err, len[10:0]}
    logic [7:0]  frm[$];     // frame bytes after SFD

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat or a status strobe.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (out_valid) begin
                if (exp_d.size() == 0) chk("unexpected_out_valid", {23'h0, out_sof, out_data}, 32'h1FF);
                else chk("out_beat", {23'h0, out_sof, out_data}, {23'h0, exp_d.pop_front()});
            end
            if (stat_valid) begin
                chk("stat_with_out_valid", {31'h0, out_valid}, 32'h0);
                if (exp_s.size() == 0) chk("unexpected_stat_valid", 32'h1, 32'h0);
                else chk("status", {17'h0, stat_good, stat_crc_err, stat_rx_err, stat_len_err, stat_len},
                         {17'h0, exp_s.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk);
        #1;
        rx_din = d;
        rx_dv  = dv;
        rx_er  = er;
    endtask

    task automatic build(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
    endtask

    // Standard Ethernet FCS: reflected CRC-32, complemented, sent LSB byte first.
    task automatic add_fcs();
        logic [31:0] c;
        c = '1;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) exp_d.push_back({(i == 0), frm[i]});
    endtask

    task automatic push_stat(input logic g, input logic c, input logic r, input logic l, input int len);
        exp_s.push_back({g, c, r, l, 11'(len)});
    endtask

    task automatic send(input int n55, input bit sfd, input int er_idx, input int ifg);
        for (int i = 0; i < n55; i++) drive(8'h55, 1'b1, 1'b0);
        if (sfd) drive(8'hD5, 1'b1, 1'b0);
        foreach (frm[i]) drive(frm[i], 1'b1, (i == er_idx));
        for (int i = 0; i < ifg; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic good_frame();
        build(60);
        add_fcs();
        push_data(60);
        push_stat(1'b1, 1'b0, 1'b0, 1'b0, 60);
        send(7, 1'b1, -1, 12);
    endtask

    initial begin
        reset  = 1'b1;
        rx_din = 8'h00;
        rx_dv  = 1'b0;
        rx_er  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {out_valid, out_sof, out_data, stat_valid, stat_good, stat_crc_err,
                              stat_rx_err, stat_len_err, stat_len}, 32'h0);
        drive(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        // 1: good 60-byte payload
        good_frame();

        // 2: payload byte 10 corrupted after FCS computed
        build(60);
        add_fcs();
        frm[10] = 8'hFF;
        push_data(60);
        push_stat(1'b0, 1'b1, 1'b0, 1'b0, 60);
        send(7, 1'b1, -1, 12);

        // 3: rx_er pulsed on payload byte 20, data still forwarded
        build(60);
        add_fcs();
        push_data(60);
        push_stat(1'b0, 1'b0, 1'b1, 1'b0, 60);
        send(7, 1'b1, 20, 12);

        // 4a: runt with valid FCS
        build(20);
        add_fcs();
        push_data(20);
        push_stat(1'b0, 1'b0, 1'b0, 1'b1, 20);
        send(7, 1'b1, -1, 12);

        // 4b: oversize, 1600 bytes after SFD, valid FCS
        build(1596);
        add_fcs();
        push_data(1515);
        push_stat(1'b0, 1'b0, 1'b0, 1'b1, 1515);
        send(7, 1'b1, -1, 12);

        // 5: bad preamble byte 0x5D -> dropped, then good frame after a 1-cycle gap
        build(60);
        frm.push_front(8'h5D);
        send(2, 1'b0, -1, 1);
        good_frame();

        // 6: reset during payload byte 30, released with rx_dv still high
        build(60);
        add_fcs();
        push_data(26);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i <= 30; i++) drive(frm[i], 1'b1, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_midframe_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_midframe_out_data", {24'h0, out_data}, 32'h0);
        for (int i = 31; i < 34; i++) drive(frm[i], 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 34; i < 64; i++) drive(frm[i], 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0);
        good_frame();

        repeat (5) drive(8'h00, 1'b0, 1'b0);
        chk("data_queue_drained", exp_d.size(), 32'h0);
        chk("status_queue_drained", exp_s.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
